bin2bcd16: RTL and testbench



---
 rtl/bin2bcd16_if.sv | 30 +++
 rtl/bin2bcd16.sv | 115 +++++++++++
 tb/tb_bin2bcd16.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd16_if.sv
// Handshake bundle between the CPU-side requester and the binary-to-BCD converter.
// The master drives start/bin; the converter (slave) returns busy/done/bcd/ovf.
interface bin2bcd16_if #(
  parameter int IN_W = 16
);
  logic            start;
  logic [IN_W-1:0] bin;
  logic            busy;
  logic            done;
  logic [15:0]     bcd;
  logic            ovf;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  ovf
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output ovf
  );
endinterface

// File: rtl/bin2bcd16.sv
// Sequential double-dabble converter, one input bit per clock, feeding a 4-digit display.
// Optional macro BCD_SAT_EN: saturate bcd to 16'h9999 when the result is >= 10000.
module bin2bcd16 #(
  parameter int IN_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  bin2bcd16_if.slave  bus
);

  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   shreg_q, shreg_d;
  logic [19:0]       acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [19:0]       acc_adj;

  // Each nibble >= 5 gets +3 independently; no carry crosses a nibble boundary.
  function automatic logic [19:0] add3(input logic [19:0] a);
    logic [19:0] r;
    r = a;
    for (int i = 0; i < 5; i++) begin
      if (a[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    acc_adj = add3(acc_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shreg_d = bus.bin;
          acc_d   = 20'd0;
          cnt_d   = CNT_W'(IN_W);
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        {acc_d, shreg_d} = {acc_adj[18:0], shreg_q, 1'b0};
        cnt_d            = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        ovf_d = (acc_q[19:16] != 4'd0);
`ifdef BCD_SAT_EN
        bcd_d = (acc_q[19:16] != 4'd0) ? 16'h9999 : acc_q[15:0];
`else
        bcd_d = acc_q[15:0];
`endif
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= 16'h0000;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd16.sv
// Scoreboard bench for bin2bcd16: stimulus pushes decimal-model results, a monitor checks each done pulse.
module tb_bin2bcd16;
  localparam int IN_W = 16;
  // Negedges from the negedge that raises start to the negedge where done is visible.
  localparam int LAT  = IN_W + 2;

  logic clk;
  logic rst;

  bin2bcd16_if #(.IN_W(IN_W)) bus ();

  bin2bcd16 #(.IN_W(IN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [16:0] exp_q[$];
  logic [15:0] hold_bcd = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal reference built from plain division, returns {ovf, bcd}.
  function automatic logic [16:0] model(input int v);
    int          r;
    logic        o;
    logic [15:0] b;
    o = (v >= 10000);
`ifdef BCD_SAT_EN
    r = o ? 9999 : v;
`else
    r = v % 10000;
`endif
    b = {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
    return {o, b};
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("bcd", 32'(bus.bcd), 32'(e[15:0]));
        check("ovf", 32'(bus.ovf), 32'(e[16]));
        hold_bcd = e[15:0];
      end
    end
  end

  task automatic issue(input int v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 16'(v);
    exp_q.push_back(model(v));
  endtask

  // Drops start on the first negedge, then counts negedges until done is seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.start = 1'b0;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done !== 1'b1) check("bcd_hold", 32'(bus.bcd), 32'(hold_bcd));
    end while (bus.done !== 1'b1 && lat < 60);
    if (bus.done !== 1'b1) check("done_timeout", 32'(lat), 32'(LAT));
  endtask

  task automatic run(input int v);
    int lat, bc;
    issue(v);
    wait_done(lat, bc);
    check("latency", 32'(lat), 32'(LAT));
  endtask

  int lat, bc;

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd",  32'(bus.bcd),  32'h0000);
    check("rst_ovf",  32'(bus.ovf),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero operand: latency and busy width.
    issue(0);
    wait_done(lat, bc);
    check("latency_zero", 32'(lat), 32'(LAT));
    check("busy_cycles", 32'(bc), 32'(IN_W + 1));
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);

    run(1234);
    run(9999);
    run(10000);
    run(65535);

    // Second start while busy and bin changes mid-conversion are ignored.
    issue(42);
    repeat (4) @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 16'd7777;
    repeat (3) @(negedge clk);
    bus.bin   = 16'd1111;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (25) @(negedge clk);
    check("ignored_start_q", 32'(exp_q.size()), 32'd0);
    check("ignored_bcd", 32'(bus.bcd), 32'h0042);

    // Reset mid-conversion: no done, outputs cleared.
    issue(5000);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    hold_bcd = 16'h0000;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_bcd",  32'(bus.bcd),  32'h0000);
    check("abort_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done_bcd", 32'(bus.bcd), 32'h0000);
    run(10);

    // Back-to-back: restart during the done cycle.
    issue(321);
    wait_done(lat, bc);
    check("b2b_lat1", 32'(lat), 32'(LAT));
    bus.start = 1'b1;
    bus.bin   = 16'd654;
    exp_q.push_back(model(654));
    wait_done(lat, bc);
    check("b2b_lat2", 32'(lat), 32'(LAT));

    // Randomized operands with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      int v;
      v = (i % 4 == 0) ? int'($urandom_range(9990, 10010)) : int'($urandom_range(0, 65535));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(v);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end
endmodule
